inst_axi_bridge: RTL and testbench

Converts the instruction cache's SRAM-like miss port (req/addr_ok/data_ok) into single-beat AXI3 read transactions on the AR/R channels. Sits directly downstream of the instruction cache and upstream of the core's AXI crossbar/arbiter. It holds at most one read outstanding, latches the request on acceptance, and returns read data to the cache with a one-cycle data_ok pulse. It also records bus errors.

---
 rtl/inst_axi_bridge_if.sv | 52 +++++
 rtl/inst_axi_bridge.sv | 92 +++++++++
 tb/tb_inst_axi_bridge.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_bridge_if.sv
// Signal bundle between the instruction cache miss port and the AXI3 AR/R channels.
// No logic here; timing is set entirely by the bridge.
// The master modport is the bridge's view; the slave modport is the cache + AXI side.
interface inst_axi_bridge_if;
  // cache side (SRAM-like)
  logic        cache_inst_req;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr;
  logic [31:0] cache_inst_rdata;
  logic        cache_inst_addr_ok;
  logic        cache_inst_data_ok;
  // AXI3 read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // AXI3 read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // status
  logic        bus_err;

  modport master (
    input  cache_inst_req, cache_inst_size, cache_inst_addr,
    output cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output bus_err
  );

  modport slave (
    output cache_inst_req, cache_inst_size, cache_inst_addr,
    input  cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  bus_err
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// Instruction-cache miss port to single-beat AXI3 read bridge, one read outstanding.
// Latency: req sampled in IDLE -> arvalid next cycle -> data_ok in the R handshake cycle (min 2 cycles).
// Backpressure: arvalid/araddr/arsize held until arready; rready held until rvalid; new req only taken in IDLE.
module inst_axi_bridge #(
  parameter logic [3:0] ARID = 4'd0
) (
  input logic             clk,
  input logic             rst,
  inst_axi_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        arvalid_r;
  logic        rready_r;
  logic        bus_err_r;

  // Transaction FSM; arvalid/rready are registered so an async reset drops them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_r    <= 32'd0;
      size_r    <= 2'd0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Address is sampled only here, once per transaction.
          if (bus.cache_inst_req) begin
            addr_r    <= bus.cache_inst_addr;
            size_r    <= bus.cache_inst_size;
            arvalid_r <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (bus.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (bus.rvalid) begin
            rready_r <= 1'b0;
            state    <= IDLE;
            // Error beats are still handed to the cache; the flag is sticky until reset.
            if (bus.rresp != 2'b00) begin
              bus_err_r <= 1'b1;
            end
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Handshake strobes to the cache are combinational so they land in the handshake cycle.
  assign bus.cache_inst_addr_ok = arvalid_r & bus.arready;
  assign bus.cache_inst_data_ok = rready_r & bus.rvalid;
  assign bus.cache_inst_rdata   = bus.rdata;

  assign bus.arid    = ARID;
  assign bus.araddr  = addr_r;
  assign bus.arlen   = 4'd0;
  assign bus.arsize  = {1'b0, size_r};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'd0;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = arvalid_r;
  assign bus.rready  = rready_r;
  assign bus.bus_err = bus_err_r;

  // rid and rlast carry no information for a single-beat, single-outstanding bridge.
  logic unused_r_fields;
  assign unused_r_fields = ^{bus.rid, bus.rlast};

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Bench for inst_axi_bridge: cache requester plus AXI slave responder with programmable waits.
// Expected address/size/data go into queues when driven and are popped at the handshakes.
// Inputs are driven 1 time unit after posedge and outputs sampled 1 unit later.
module tb_inst_axi_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_axi_bridge_if bus();

  inst_axi_bridge #(.ARID(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr_q[$];
  logic [1:0]  exp_size_q[$];
  logic [31:0] exp_data_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete read; caller is 1 unit after a posedge with the DUT expected in IDLE.
  // Returns at the data_ok cycle.
  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input int arw, input int rw,
                         input logic [31:0] d, input logic [1:0] resp, input bit chg_addr);
    int cyc;
    int waited;
    logic [31:0] ea;
    logic [1:0]  es;
    logic [31:0] ed;
    cyc = 0;
    bus.cache_inst_req  = 1'b1;
    bus.cache_inst_addr = a;
    bus.cache_inst_size = sz;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    exp_addr_q.push_back(a);
    exp_size_q.push_back(sz);
    exp_data_q.push_back(d);
    #1;
    chk("idle_arvalid", bus.arvalid, 0);
    chk("idle_addr_ok", bus.cache_inst_addr_ok, 0);
    // AR phase
    waited = 0;
    while (1) begin
      step();
      cyc++;
      bus.arready = (waited >= arw);
      if (chg_addr) bus.cache_inst_addr = 32'hFFFF_FFFF;
      #1;
      chk("ar_arvalid", bus.arvalid, 1);
      chk("ar_rready", bus.rready, 0);
      chk("ar_addr_ok", bus.cache_inst_addr_ok, bus.arready);
      if (exp_addr_q.size() == 0) begin
        chk("sb_addr_empty", 1, 0);
      end else begin
        chk("ar_araddr", bus.araddr, exp_addr_q[0]);
      end
      if (bus.arready) begin
        if (exp_addr_q.size() > 0 && exp_size_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          es = exp_size_q.pop_front();
          chk("hs_araddr", bus.araddr, ea);
          chk("hs_arsize", {29'd0, bus.arsize}, {29'd0, 1'b0, es});
          chk("hs_arlen", {28'd0, bus.arlen}, 0);
          chk("hs_arburst", {30'd0, bus.arburst}, 1);
          chk("hs_arid", {28'd0, bus.arid}, 0);
        end
        break;
      end
      waited++;
    end
    // R phase
    waited = 0;
    while (1) begin
      step();
      cyc++;
      bus.cache_inst_req = 1'b0;
      bus.arready = 1'b0;
      bus.rvalid  = (waited >= rw);
      bus.rdata   = bus.rvalid ? d : 32'h5A5A_5A5A;
      bus.rresp   = bus.rvalid ? resp : 2'b00;
      #1;
      chk("r_rready", bus.rready, 1);
      chk("r_arvalid", bus.arvalid, 0);
      chk("r_addr_ok", bus.cache_inst_addr_ok, 0);
      chk("r_data_ok", bus.cache_inst_data_ok, bus.rvalid);
      if (bus.rvalid) begin
        if (exp_data_q.size() == 0) begin
          chk("sb_data_empty", 1, 0);
        end else begin
          ed = exp_data_q.pop_front();
          chk("r_rdata", bus.cache_inst_rdata, ed);
        end
        chk("latency", cyc, 2 + arw + rw);
        break;
      end
      waited++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cache_inst_req  = 1'b0;
    bus.cache_inst_size = 2'd0;
    bus.cache_inst_addr = 32'd0;
    bus.arready = 1'b0;
    bus.rid     = 4'd0;
    bus.rdata   = 32'd0;
    bus.rresp   = 2'd0;
    bus.rlast   = 1'b1;
    bus.rvalid  = 1'b0;

    // reset state
    #2;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_addr_ok", bus.cache_inst_addr_ok, 0);
    chk("rst_data_ok", bus.cache_inst_data_ok, 0);
    chk("rst_bus_err", bus.bus_err, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_arsize", {29'd0, bus.arsize}, 0);
    chk("rst_arburst", {30'd0, bus.arburst}, 1);
    chk("rst_arlen", {28'd0, bus.arlen}, 0);
    #10 rst = 1'b1;
    step();

    // single read, zero wait
    do_read(32'hBFC0_0000, 2'd2, 0, 0, 32'h3C08_BFC0, 2'b00, 1'b0);
    step();
    // wait states: 3 AR stalls, 5 R stalls
    do_read(32'h0000_0100, 2'd2, 3, 5, 32'h1111_2222, 2'b00, 1'b0);
    step();
    // back-to-back: second request in the cycle right after data_ok
    do_read(32'h0000_0000, 2'd2, 0, 0, 32'hA0A0_0001, 2'b00, 1'b0);
    step();
    do_read(32'h0000_0004, 2'd2, 0, 0, 32'hA0A0_0002, 2'b00, 1'b0);
    step();
    chk("pre_err_bus_err", bus.bus_err, 0);
    // error response
    do_read(32'h0000_0020, 2'd2, 0, 1, 32'hDEAD_BEEF, 2'b10, 1'b0);
    step();
    bus.rvalid = 1'b0;
    #1;
    chk("err_bus_err", bus.bus_err, 1);
    do_read(32'h0000_0024, 2'd2, 1, 0, 32'h1234_5678, 2'b00, 1'b0);
    step();
    bus.rvalid = 1'b0;
    #1;
    chk("err_sticky", bus.bus_err, 1);
    // address stability while stalled in AR, half-word size
    do_read(32'h0000_0040, 2'd1, 3, 0, 32'h0000_BEEF, 2'b00, 1'b1);
    step();

    // reset while in R
    bus.rvalid = 1'b0;
    bus.cache_inst_req  = 1'b1;
    bus.cache_inst_addr = 32'h0000_0080;
    bus.cache_inst_size = 2'd2;
    step();
    bus.arready = 1'b1;
    #1;
    chk("mid_addr_ok", bus.cache_inst_addr_ok, 1);
    step();
    bus.cache_inst_req = 1'b0;
    bus.arready = 1'b0;
    #1;
    chk("mid_rready", bus.rready, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rready", bus.rready, 0);
    chk("mid_rst_arvalid", bus.arvalid, 0);
    chk("mid_rst_bus_err", bus.bus_err, 0);
    chk("mid_rst_araddr", bus.araddr, 0);
    #2 rst = 1'b1;
    step();
    do_read(32'h0000_0010, 2'd2, 1, 2, 32'hCAFE_F00D, 2'b00, 1'b0);
    step();
    bus.rvalid = 1'b0;
    #1;
    chk("post_rst_bus_err", bus.bus_err, 0);

    chk("sb_addr_left", exp_addr_q.size(), 0);
    chk("sb_data_left", exp_data_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
